// File: rtl/cache_wb_buffer_pkg.sv
// cache_wb_buffer_pkg
// Shared sizing constants and the FSM state encoding for the write-back
// buffer that sits between the L1 data array and main memory.
//   WB_PA_WIDTH  : physical address width
//   WB_MEM_WIDTH : cache block width in bits (64 B)
//   WB_BO_WIDTH  : block-offset bits, ignored in every address compare
//   WB_DEPTH     : number of buffer entries (power of 2, >= 2)
package cache_wb_buffer_pkg;

  localparam int WB_PA_WIDTH  = 32;
  localparam int WB_MEM_WIDTH = 512;
  localparam int WB_BO_WIDTH  = 6;
  localparam int WB_DEPTH     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_FWD = 2'd1,
    RD_MEM = 2'd2,
    WR_MEM = 2'd3
  } wb_state_e;

endpackage

// File: rtl/cache_wb_buffer_if.sv
// cache_wb_buffer_if
// Bundles every handshake/bus signal of the write-back buffer.
//   victim push : in_valid, in_addr, in_blk, in_ready
//   refill      : rd_req_valid, rd_addr, rd_req_ready, rd_resp_valid, rd_resp_blk
//   memory write: mem_wr_req, mem_wr_addr, mem_wr_blk, mem_wr_ack
//   memory read : mem_rd_req, mem_rd_addr, mem_rd_ack, mem_rd_blk
//   status      : count
// Modports:
//   master : the environment (cache + memory) that drives the buffer inputs
//   slave  : the buffer itself
interface cache_wb_buffer_if
  import cache_wb_buffer_pkg::*;
#(
  parameter int PA_WIDTH  = WB_PA_WIDTH,
  parameter int MEM_WIDTH = WB_MEM_WIDTH,
  parameter int DEPTH     = WB_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic [PA_WIDTH-1:0]  in_addr;
  logic [MEM_WIDTH-1:0] in_blk;
  logic                 in_ready;

  logic                 rd_req_valid;
  logic [PA_WIDTH-1:0]  rd_addr;
  logic                 rd_req_ready;
  logic                 rd_resp_valid;
  logic [MEM_WIDTH-1:0] rd_resp_blk;

  logic                 mem_wr_req;
  logic [PA_WIDTH-1:0]  mem_wr_addr;
  logic [MEM_WIDTH-1:0] mem_wr_blk;
  logic                 mem_wr_ack;

  logic                 mem_rd_req;
  logic [PA_WIDTH-1:0]  mem_rd_addr;
  logic                 mem_rd_ack;
  logic [MEM_WIDTH-1:0] mem_rd_blk;

  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, in_addr, in_blk,
    input  in_ready,
    output rd_req_valid, rd_addr,
    input  rd_req_ready, rd_resp_valid, rd_resp_blk,
    input  mem_wr_req, mem_wr_addr, mem_wr_blk,
    output mem_wr_ack,
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_ack, mem_rd_blk,
    input  count
  );

  modport slave (
    input  in_valid, in_addr, in_blk,
    output in_ready,
    input  rd_req_valid, rd_addr,
    output rd_req_ready, rd_resp_valid, rd_resp_blk,
    output mem_wr_req, mem_wr_addr, mem_wr_blk,
    input  mem_wr_ack,
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_ack, mem_rd_blk,
    output count
  );

endinterface

// File: rtl/cache_wb_buffer_addr_match.sv
// wb_addr_match
// Associative lookup over the circular buffer. Walks the occupied slots from
// oldest (head) to youngest and reports the youngest slot whose block address
// equals the lookup block address; block-offset bits are ignored.
// Ports:
//   ent_vld     : per-entry valid bits
//   ent_addr    : per-entry stored (block-aligned) addresses
//   lookup_addr : address to search for
//   head, count : oldest slot and number of slots to consider
//   hit, idx    : match flag and youngest matching slot
module wb_addr_match
  import cache_wb_buffer_pkg::*;
#(
  parameter  int PA_WIDTH = WB_PA_WIDTH,
  parameter  int BO_WIDTH = WB_BO_WIDTH,
  parameter  int DEPTH    = WB_DEPTH,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic [DEPTH-1:0]               ent_vld,
  input  logic [DEPTH-1:0][PA_WIDTH-1:0] ent_addr,
  input  logic [PA_WIDTH-1:0]            lookup_addr,
  input  logic [PTR_W-1:0]               head,
  input  logic [CNT_W-1:0]               count,
  output logic                           hit,
  output logic [PTR_W-1:0]               idx
);

  logic [PTR_W-1:0] slot;
  logic [DEPTH-1:0] unused_offs;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      unused_offs[i] = ^ent_addr[i][BO_WIDTH-1:0] ^ (^lookup_addr[BO_WIDTH-1:0]);
    end
  end

  // Later (younger) matches overwrite earlier ones, so the last hit wins.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = head;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && ent_vld[slot] &&
          (ent_addr[slot][PA_WIDTH-1:BO_WIDTH] == lookup_addr[PA_WIDTH-1:BO_WIDTH])) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer
// Write-back buffer between the 4-way L1 data array and main memory. Dirty
// victim blocks are queued in a circular FIFO and drained to memory in order.
// Refill reads are forwarded from the youngest matching queued victim, or sent
// to memory when nothing matches, so a refill never sees stale data while a
// victim is still waiting to be written back.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : cache_wb_buffer_if.slave (victim push, refill, memory read and
//              write channels, occupancy count)
// Optional build macro:
//   WB_COALESCE_EN : a push that hits a queued entry (other than the head that
//                    is currently being written) overwrites that entry's data
//                    instead of allocating a new one.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int PA_WIDTH  = WB_PA_WIDTH,
  parameter int MEM_WIDTH = WB_MEM_WIDTH,
  parameter int BO_WIDTH  = WB_BO_WIDTH,
  parameter int DEPTH     = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  cache_wb_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] a);
    return {a[PA_WIDTH-1:BO_WIDTH], {BO_WIDTH{1'b0}}};
  endfunction

  logic [DEPTH-1:0][PA_WIDTH-1:0]  ent_addr;
  logic [DEPTH-1:0][MEM_WIDTH-1:0] ent_blk;
  logic [DEPTH-1:0]                ent_vld;
  logic [PTR_W-1:0]                head;
  logic [PTR_W-1:0]                tail;
  logic [CNT_W-1:0]                cnt;

  logic [PA_WIDTH-1:0]             rd_addr_q;
  logic [MEM_WIDTH-1:0]            resp_q;

  wb_state_e state_q, state_d;

  logic             full, push, alloc, merge, pop, rd_ready, rd_acc;
  logic             rd_hit, co_hit;
  logic [PTR_W-1:0] rd_idx, co_idx;

  wb_addr_match #(
    .PA_WIDTH (PA_WIDTH),
    .BO_WIDTH (BO_WIDTH),
    .DEPTH    (DEPTH)
  ) u_rd_match (
    .ent_vld     (ent_vld),
    .ent_addr    (ent_addr),
    .lookup_addr (bus.rd_addr),
    .head        (head),
    .count       (cnt),
    .hit         (rd_hit),
    .idx         (rd_idx)
  );

`ifdef WB_COALESCE_EN
  // The head being written to memory is excluded by starting the search one
  // slot later; coalescing into it would lose the update once it pops.
  logic [PTR_W-1:0] co_head;
  logic [CNT_W-1:0] co_cnt;

  assign co_head = (state_q == WR_MEM) ? head + PTR_W'(1) : head;
  assign co_cnt  = (state_q == WR_MEM) ? cnt - CNT_W'(1)  : cnt;

  wb_addr_match #(
    .PA_WIDTH (PA_WIDTH),
    .BO_WIDTH (BO_WIDTH),
    .DEPTH    (DEPTH)
  ) u_co_match (
    .ent_vld     (ent_vld),
    .ent_addr    (ent_addr),
    .lookup_addr (bus.in_addr),
    .head        (co_head),
    .count       (co_cnt),
    .hit         (co_hit),
    .idx         (co_idx)
  );
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;
`endif

  assign full         = (cnt == CNT_W'(DEPTH));
  // A same-cycle pop does not free a slot for the push.
  assign bus.in_ready = !full || co_hit;
  assign push         = bus.in_valid && bus.in_ready;
  assign alloc        = push && !co_hit;
  assign merge        = push && co_hit;
  assign pop          = (state_q == WR_MEM) && bus.mem_wr_ack;

  // Victim pushes win over refills; when full the drain wins, so the refill
  // is held off rather than accepted and left waiting.
  assign rd_ready          = (state_q == IDLE) && !bus.in_valid && !full;
  assign rd_acc            = bus.rd_req_valid && rd_ready;
  assign bus.rd_req_ready  = rd_ready;

  assign bus.rd_resp_valid = (state_q == RD_FWD);
  assign bus.rd_resp_blk   = bus.rd_resp_valid ? resp_q : '0;
  assign bus.mem_wr_req    = (state_q == WR_MEM);
  assign bus.mem_wr_addr   = bus.mem_wr_req ? ent_addr[head] : '0;
  assign bus.mem_wr_blk    = bus.mem_wr_req ? ent_blk[head]  : '0;
  assign bus.mem_rd_req    = (state_q == RD_MEM);
  assign bus.mem_rd_addr   = bus.mem_rd_req ? rd_addr_q : '0;
  assign bus.count         = cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (full)                state_d = WR_MEM;
        else if (rd_acc)         state_d = rd_hit ? RD_FWD : RD_MEM;
        else if (cnt != '0)      state_d = WR_MEM;
      end
      RD_FWD:                    state_d = IDLE;
      // Memory refill data is replayed through RD_FWD for the response pulse.
      RD_MEM: if (bus.mem_rd_ack) state_d = RD_FWD;
      WR_MEM: if (bus.mem_wr_ack) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      state_q <= state_d;
      if (alloc) begin
        tail          <= tail + PTR_W'(1);
        ent_vld[tail] <= 1'b1;
      end
      if (pop) begin
        head          <= head + PTR_W'(1);
        ent_vld[head] <= 1'b0;
      end
      case ({alloc, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= blk_align(bus.in_addr);
      ent_blk[tail]  <= bus.in_blk;
    end
    if (merge) begin
      ent_blk[co_idx] <= bus.in_blk;
    end
    if (rd_acc) begin
      rd_addr_q <= blk_align(bus.rd_addr);
      if (rd_hit) resp_q <= ent_blk[rd_idx];
    end
    if ((state_q == RD_MEM) && bus.mem_rd_ack) begin
      resp_q <= bus.mem_rd_blk;
    end
  end

endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb_cache_wb_buffer
// Self-checking bench for cache_wb_buffer. A queue-based model of the buffer
// contents predicts occupancy, drain order/data and refill responses; a small
// memory responder acks requests after random latencies and injects stray acks.
module tb_cache_wb_buffer;

  localparam int PA    = 32;
  localparam int MW    = 512;
  localparam int BO    = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_wb_buffer_if #(.PA_WIDTH(PA), .MEM_WIDTH(MW), .DEPTH(DEPTH)) bus ();

  cache_wb_buffer #(
    .PA_WIDTH (PA),
    .MEM_WIDTH(MW),
    .BO_WIDTH (BO),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  typedef struct {
    logic [PA-1:0] a;
    logic [MW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          mon_en = 1'b0;
  logic          hold_wr = 1'b0;
  logic          rd_out, rd_busy, resp_next, resp_now, fwd_next, fwd_now;
  logic [PA-1:0] rd_exp_addr;
  logic [MW-1:0] resp_blk_exp;
  int            rd_age, co, h, wr_lat, rd_lat;
  logic          exp_ready;
  ent_t          e;

  function automatic logic [PA-1:0] align(input logic [PA-1:0] a);
    return {a[PA-1:BO], 6'b0};
  endfunction

  function automatic logic [MW-1:0] rnd_blk();
    logic [MW-1:0] r;
    for (int i = 0; i < MW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int youngest(input logic [PA-1:0] a, input int lo);
    for (int i = q.size() - 1; i >= lo; i--)
      if (q[i].a[PA-1:BO] == a[PA-1:BO]) return i;
    return -1;
  endfunction

  // Model and monitor: sample mid-cycle, predict the effect of the next edge.
  initial begin
    rd_out = 0; rd_busy = 0; resp_next = 0; fwd_next = 0; rd_age = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        rd_out = 0; rd_busy = 0; resp_next = 0; fwd_next = 0; rd_age = 0;
      end else if (mon_en) begin
        resp_now = resp_next; resp_next = 0;
        fwd_now  = fwd_next;  fwd_next  = 0;
        co = -1;
`ifdef WB_COALESCE_EN
        co = youngest(bus.in_addr, bus.mem_wr_req ? 1 : 0);
`endif
        exp_ready = (q.size() != DEPTH) || (co >= 0);
        check("count", bus.count, q.size());
        check("in_ready", bus.in_ready, exp_ready);
        check("req_excl", bus.mem_wr_req & bus.mem_rd_req, 0);
        check("resp_valid", bus.rd_resp_valid, resp_now);
        if (resp_now) begin
          check("resp_blk", bus.rd_resp_blk, resp_blk_exp);
          rd_busy = 0;
        end
        if (fwd_now) check("fwd_no_memrd", bus.mem_rd_req, 0);
        if (bus.mem_rd_req) begin
          check("memrd_expected", rd_out, 1);
          check("mem_rd_addr", bus.mem_rd_addr, rd_exp_addr);
          if (bus.mem_rd_ack) begin
            resp_next = 1; resp_blk_exp = bus.mem_rd_blk; rd_out = 0;
          end
        end
        if (bus.rd_req_valid && bus.rd_req_ready) begin
          check("rd_vs_push", bus.in_valid, 0);
          check("rd_when_full", q.size() == DEPTH, 0);
          check("rd_overlap", rd_busy, 0);
          h = youngest(bus.rd_addr, 0);
          if (h >= 0) begin
            resp_next = 1; resp_blk_exp = q[h].d; fwd_next = 1;
          end else begin
            rd_out = 1; rd_exp_addr = align(bus.rd_addr);
          end
          rd_busy = 1; rd_age = 0;
        end
        if (rd_busy) begin
          rd_age++;
          if (rd_age > 100) begin
            check("rd_timeout", rd_busy, 0);
            rd_busy = 0; rd_out = 0;
          end
        end
        if (bus.mem_wr_req) check("wr_req_nonempty", q.size() > 0, 1);
        // Apply the push before the pop so coalesce indices refer to the
        // queue as it stands this cycle.
        if (bus.in_valid && exp_ready) begin
          if (co >= 0) begin
            e = q[co]; e.d = bus.in_blk; q[co] = e;
          end else begin
            e.a = align(bus.in_addr); e.d = bus.in_blk; q.push_back(e);
          end
        end
        if (bus.mem_wr_req && bus.mem_wr_ack && q.size() > 0) begin
          check("wr_addr", bus.mem_wr_addr, q[0].a);
          check("wr_blk", bus.mem_wr_blk, q[0].d);
          void'(q.pop_front());
        end
      end
    end
  end

  // Memory responder: random latency acks, plus stray acks when idle.
  initial begin
    bus.mem_wr_ack = 0; bus.mem_rd_ack = 0; bus.mem_rd_blk = '0;
    wr_lat = 2; rd_lat = 3;
    forever begin
      @(posedge clk); #1;
      bus.mem_wr_ack = 0;
      bus.mem_rd_ack = 0;
      if (bus.mem_wr_req) begin
        if (!hold_wr) begin
          if (wr_lat == 0) begin bus.mem_wr_ack = 1; wr_lat = $urandom_range(0, 3); end
          else wr_lat--;
        end
      end else if ($urandom_range(0, 7) == 0) bus.mem_wr_ack = 1;
      if (bus.mem_rd_req) begin
        if (rd_lat == 0) begin
          bus.mem_rd_ack = 1; bus.mem_rd_blk = rnd_blk(); rd_lat = $urandom_range(0, 3);
        end else rd_lat--;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_rd_ack = 1; bus.mem_rd_blk = rnd_blk();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_push(input logic [PA-1:0] a, input logic [MW-1:0] d);
    logic acc = 0;
    bus.in_valid = 1; bus.in_addr = a; bus.in_blk = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
    end
    check("push_timeout", acc, 1);
    bus.in_valid = 0;
  endtask

  task automatic do_refill(input logic [PA-1:0] a);
    logic acc = 0;
    bus.rd_req_valid = 1; bus.rd_addr = a;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = bus.rd_req_ready;
      @(posedge clk); #1;
    end
    check("refill_timeout", acc, 1);
    bus.rd_req_valid = 0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (q.size() != 0 || rd_busy); i++) tick(1);
    tick(2);
    check("drain_done", (q.size() == 0) && !rd_busy, 1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_addr = '0; bus.in_blk = '0;
    bus.rd_req_valid = 0; bus.rd_addr = '0;
    tick(2);
    @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_resp_valid", bus.rd_resp_valid, 0);
    check("rst_wr_req", bus.mem_wr_req, 0);
    check("rst_rd_req", bus.mem_rd_req, 0);
    check("rst_wr_addr", bus.mem_wr_addr, 0);
    check("rst_wr_blk", bus.mem_wr_blk, 0);
    check("rst_rd_addr", bus.mem_rd_addr, 0);
    check("rst_resp_blk", bus.rd_resp_blk, 0);
    @(posedge clk); #1;
    rst = 0; mon_en = 1;

    // Single victim drained to memory.
    do_push(32'h0000_1040, {16{32'hAAAA_AAAA}});
    wait_drain(50);

    // Refill hitting a queued victim is forwarded.
    hold_wr = 1;
    do_push(32'h0000_1040, {16{32'hAAAA_AAAA}});
    do_refill(32'h0000_1064);
    tick(3);
    hold_wr = 0;
    wait_drain(50);

    // Refill miss goes to memory.
    do_refill(32'h0000_2000);
    wait_drain(50);

    // Fill with writes stalled, try a fifth push, then in-order drain.
    hold_wr = 1;
    for (int k = 1; k <= 4; k++) do_push(PA'(k << 6), rnd_blk());
    bus.in_valid = 1; bus.in_addr = 32'h0000_0140; bus.in_blk = rnd_blk();
    tick(3);
    bus.in_valid = 0;
    hold_wr = 0;
    wait_drain(100);

    // Reset while a write is in flight with three entries queued.
    hold_wr = 1;
    for (int k = 1; k <= 3; k++) do_push(PA'(32'h3000 + (k << 6)), rnd_blk());
    tick(2);
    rst = 1;
    tick(1);
    rst = 0;
    hold_wr = 0;
    @(negedge clk);
    check("midrst_count", bus.count, 0);
    check("midrst_wr_req", bus.mem_wr_req, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    tick(1);

    // Same block pushed twice back to back.
    do_push(32'h0000_1040, {16{32'h1111_1111}});
    do_push(32'h0000_1048, {16{32'h2222_2222}});
    @(negedge clk);
`ifdef WB_COALESCE_EN
    check("dup_count", bus.count, 1);
`else
    check("dup_count", bus.count, 2);
`endif
    @(posedge clk); #1;
    wait_drain(100);

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid     = ($urandom_range(0, 2) == 0);
      bus.in_addr      = 32'h0000_1000 + ($urandom_range(0, 5) << 6) + $urandom_range(0, 63);
      bus.in_blk       = rnd_blk();
      bus.rd_req_valid = ($urandom_range(0, 2) == 0);
      bus.rd_addr      = 32'h0000_1000 + ($urandom_range(0, 7) << 6) + $urandom_range(0, 63);
      hold_wr          = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    bus.in_valid = 0; bus.rd_req_valid = 0; hold_wr = 0;
    wait_drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
